carbon_csr_bank: RTL and testbench

Word-addressed CSR slave that terminates one csr_if channel on its slave side. It is the stage directly downstream of any csr_if master: it accepts requests, decodes them against a small fixed register map (ID, W1C event, 64-bit cycle counter, scratch), and returns registered responses with fault and side-effect reporting. It is the default endpoint for per-core and per-subsystem control/status space.

---
 rtl/carbon_csr_pkg.sv | 41 ++++
 rtl/carbon_csr_bank_decode.sv | 69 ++++++
 rtl/carbon_csr_bank.sv | 216 +++++++++++++++++++++
 tb/tb_carbon_csr_bank.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/carbon_csr_pkg.sv
// carbon_csr_pkg
// Shared definitions for the carbon CSR bank: register word indices, the
// access-class enumeration produced by the decoder, the registered response
// bundle and a byte-strobe expansion helper.
// Build option: CARBON_CSR_BANK_CYCLE_CNT_EN (consumed by the bank and decoder).
package carbon_csr_pkg;

  localparam int CSR_DATA_W = 32;
  localparam int CSR_STRB_W = CSR_DATA_W / 8;
  localparam int CSR_IDX_W  = 4;

  localparam logic [CSR_IDX_W-1:0] CSR_IDX_ID       = 4'd0;
  localparam logic [CSR_IDX_W-1:0] CSR_IDX_EVENT    = 4'd1;
  localparam logic [CSR_IDX_W-1:0] CSR_IDX_CYC_LO   = 4'd2;
  localparam logic [CSR_IDX_W-1:0] CSR_IDX_CYC_HI   = 4'd3;
  localparam logic [CSR_IDX_W-1:0] CSR_IDX_SCRATCH0 = 4'd4;

  typedef enum logic [1:0] {
    CSR_RO   = 2'd0,
    CSR_RW   = 2'd1,
    CSR_W1C  = 2'd2,
    CSR_NONE = 2'd3
  } csr_access_e;

  typedef struct packed {
    logic [CSR_DATA_W-1:0] rdata;
    logic                  fault;
    logic                  side_effect;
  } csr_rsp_t;

  // Expand a byte strobe into a per-bit write mask.
  function automatic logic [CSR_DATA_W-1:0] strb_to_mask(input logic [CSR_STRB_W-1:0] strb);
    logic [CSR_DATA_W-1:0] mask;
    mask = '0;
    for (int b = 0; b < CSR_STRB_W; b++) begin
      mask[b*8 +: 8] = {8{strb[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/carbon_csr_bank_decode.sv
// carbon_csr_bank_decode
// Purely combinational address decoder for the carbon CSR bank.
// Ports:
//   addr   in  ADDR_W  request byte address
//   write  in  1       request is a write
//   priv   in  PRIV_W  requester privilege
//   idx    out         word index relative to BASE_ADDR (valid when access != CSR_NONE)
//   access out         access class of the addressed register
//   fault  out         misaligned / below base / unmapped / privilege / write-to-RO
// Build option: CARBON_CSR_BANK_CYCLE_CNT_EN -- when undefined the cycle counter
// words decode as unmapped.
module carbon_csr_bank_decode
  import carbon_csr_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                PRIV_W      = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0100,
  parameter int                NUM_SCRATCH = 4,
  parameter logic [PRIV_W-1:0] MIN_PRIV    = 2'd1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              write,
  input  logic [PRIV_W-1:0] priv,
  output logic [CSR_IDX_W-1:0] idx,
  output csr_access_e       access,
  output logic              fault
);

  logic [ADDR_W-1:0] offset_s;
  logic [ADDR_W-1:0] word_s;
  logic              misalign_s;
  logic              below_s;
  logic              in_range_s;

  // Word index and coarse range qualification of the address.
  always_comb begin
    offset_s   = addr - BASE_ADDR;
    word_s     = offset_s >> 2;
    misalign_s = (addr[1:0] != 2'b00);
    below_s    = (addr < BASE_ADDR);
    // Compare on the full word so large offsets cannot alias into the map.
    in_range_s = (word_s < ADDR_W'(int'(CSR_IDX_SCRATCH0) + NUM_SCRATCH));
    idx        = word_s[CSR_IDX_W-1:0];
  end

  // Access class per register and the resulting fault decision.
  always_comb begin
    access = CSR_NONE;
    if (misalign_s || below_s || !in_range_s) begin
      access = CSR_NONE;
    end else begin
      case (idx)
        CSR_IDX_ID:    access = CSR_RO;
        CSR_IDX_EVENT: access = CSR_W1C;
        CSR_IDX_CYC_LO,
        CSR_IDX_CYC_HI: begin
`ifdef CARBON_CSR_BANK_CYCLE_CNT_EN
          access = CSR_RO;
`else
          access = CSR_NONE;
`endif
        end
        default:       access = CSR_RW;
      endcase
    end
    fault = (access == CSR_NONE) || (priv < MIN_PRIV) || (write && (access == CSR_RO));
  end

endmodule

// File: rtl/carbon_csr_bank.sv
// carbon_csr_bank
// Word-addressed CSR slave terminating one csr_if channel. Holds the ID,
// W1C event, 64-bit cycle counter (optional) and scratch registers, and
// returns one registered response per accepted request.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (req_ready = !rsp_valid || rsp_ready)
//   req_write, req_addr, req_wdata, req_wstrb, req_priv   request payload
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata, rsp_fault, rsp_side_effect                 registered response payload
//   event_i                    one-cycle event pulses, one bit per source
//   irq_o                      registered OR of the event register
// Build option: CARBON_CSR_BANK_CYCLE_CNT_EN -- when defined, the cycle
// counter and its high-word shadow are built and words 2/3 are readable;
// otherwise those words fault as unmapped.
module carbon_csr_bank
  import carbon_csr_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                PRIV_W      = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0100,
  parameter int                NUM_SCRATCH = 4,
  parameter logic [PRIV_W-1:0] MIN_PRIV    = 2'd1,
  parameter logic [31:0]       ID_VALUE    = 32'hCA2B_0001
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  input  logic [PRIV_W-1:0]   req_priv,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_fault,
  output logic                rsp_side_effect,
  input  logic [DATA_W-1:0]   event_i,
  output logic                irq_o
);

  // Parameter legality is checked at elaboration.
  if (DATA_W != 32) begin : g_bad_data_w
    $error("carbon_csr_bank: DATA_W must be 32");
  end
  if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
    $error("carbon_csr_bank: BASE_ADDR must be 4-byte aligned");
  end
  if ((NUM_SCRATCH < 1) || (NUM_SCRATCH > 8)) begin : g_bad_scratch
    $error("carbon_csr_bank: NUM_SCRATCH must be 1..8");
  end

  logic [CSR_IDX_W-1:0] idx_s;
  csr_access_e          access_s;
  logic                 dec_fault_s;
  logic                 accept_s;
  logic                 commit_s;
  logic [DATA_W-1:0]    byte_mask_s;
  logic [DATA_W-1:0]    wr_clear_s;
  logic [DATA_W-1:0]    clear_mask_s;
  logic [DATA_W-1:0]    event_next_s;
  logic [DATA_W-1:0]    scratch_rd_s;
  logic [DATA_W-1:0]    rdata_s;
  logic [31:0]          cyc_lo_s;
  logic [31:0]          cyc_hi_s;
  csr_rsp_t             rsp_next_s;

  logic [DATA_W-1:0]    event_r;
  logic [DATA_W-1:0]    scratch_r [NUM_SCRATCH];
  logic                 irq_r;
  logic                 rsp_valid_r;
  csr_rsp_t             rsp_r;

  carbon_csr_bank_decode #(
    .ADDR_W      (ADDR_W),
    .PRIV_W      (PRIV_W),
    .BASE_ADDR   (BASE_ADDR),
    .NUM_SCRATCH (NUM_SCRATCH),
    .MIN_PRIV    (MIN_PRIV)
  ) u_decode (
    .addr   (req_addr),
    .write  (req_write),
    .priv   (req_priv),
    .idx    (idx_s),
    .access (access_s),
    .fault  (dec_fault_s)
  );

  assign req_ready = !rsp_valid_r || rsp_ready;
  assign accept_s  = req_valid && req_ready;
  // A faulted access must leave all state untouched.
  assign commit_s  = accept_s && !dec_fault_s;

  // Write masks derived from the byte strobes.
  always_comb begin
    byte_mask_s  = strb_to_mask(req_wstrb);
    wr_clear_s   = req_wdata & byte_mask_s;
    clear_mask_s = '0;
    if (commit_s && req_write && (access_s == CSR_W1C)) begin
      clear_mask_s = wr_clear_s;
    end else begin
      clear_mask_s = '0;
    end
    // Set is OR-ed in after the clear, so a same-cycle pulse wins.
    event_next_s = (event_r & ~clear_mask_s) | event_i;
  end

`ifdef CARBON_CSR_BANK_CYCLE_CNT_EN
  logic [63:0] cycle_r;
  logic [31:0] shadow_r;

  // Free-running cycle counter; a CYCLE_LO read captures the high half so a
  // following CYCLE_HI read is coherent with the low half already returned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_r  <= 64'd0;
      shadow_r <= 32'd0;
    end else begin
      cycle_r <= cycle_r + 64'd1;
      if (commit_s && !req_write && (idx_s == CSR_IDX_CYC_LO)) begin
        shadow_r <= cycle_r[63:32];
      end
    end
  end

  assign cyc_lo_s = cycle_r[31:0];
  assign cyc_hi_s = shadow_r;
`else
  assign cyc_lo_s = 32'd0;
  assign cyc_hi_s = 32'd0;
`endif

  // Scratch read selection (one-hot OR across the array).
  always_comb begin
    scratch_rd_s = '0;
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      scratch_rd_s = scratch_rd_s |
                     ((idx_s == CSR_IDX_W'(int'(CSR_IDX_SCRATCH0) + i)) ? scratch_r[i] : '0);
    end
  end

  // Read data mux and next response contents.
  always_comb begin
    rdata_s = '0;
    case (idx_s)
      CSR_IDX_ID:     rdata_s = ID_VALUE;
      CSR_IDX_EVENT:  rdata_s = event_r;
      CSR_IDX_CYC_LO: rdata_s = cyc_lo_s;
      CSR_IDX_CYC_HI: rdata_s = cyc_hi_s;
      default:        rdata_s = scratch_rd_s;
    endcase

    rsp_next_s = '0;
    if (dec_fault_s) begin
      rsp_next_s.fault = 1'b1;
    end else if (req_write) begin
      rsp_next_s.side_effect = (access_s == CSR_W1C) && (|wr_clear_s);
    end else begin
      rsp_next_s.rdata       = rdata_s;
      rsp_next_s.side_effect = (idx_s == CSR_IDX_CYC_LO);
    end
  end

  // Event register and its interrupt, which trails the register by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_r <= '0;
      irq_r   <= 1'b0;
    end else begin
      event_r <= event_next_s;
      irq_r   <= |event_r;
    end
  end

  // Byte-strobed scratch writes commit on the acceptance edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        scratch_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (commit_s && req_write && (idx_s == CSR_IDX_W'(int'(CSR_IDX_SCRATCH0) + i))) begin
          for (int b = 0; b < DATA_W/8; b++) begin
            if (req_wstrb[b]) begin
              scratch_r[i][b*8 +: 8] <= req_wdata[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // Response register: loads on accept, holds while stalled, drops on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_r       <= '0;
    end else if (accept_s) begin
      rsp_valid_r <= 1'b1;
      rsp_r       <= rsp_next_s;
    end else if (rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end
  end

  assign rsp_valid       = rsp_valid_r;
  assign rsp_rdata       = rsp_r.rdata;
  assign rsp_fault       = rsp_r.fault;
  assign rsp_side_effect = rsp_r.side_effect;
  assign irq_o           = irq_r;

endmodule

// File: tb/tb_carbon_csr_bank.sv
// tb_carbon_csr_bank
// Self-checking bench for carbon_csr_bank. Requests push their expected
// response onto a scoreboard queue; a monitor pops and compares each
// response as it is handed off. Scenario tasks add inline checks on reset
// state, interrupt timing, back-pressure and throughput.
module tb_carbon_csr_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic [1:0]  req_priv;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        rsp_side_effect;
  logic [31:0] event_i;
  logic        irq_o;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        fault;
    logic        se;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   last_stalls = 0;

  carbon_csr_bank dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_wstrb       (req_wstrb),
    .req_priv        (req_priv),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_rdata       (rsp_rdata),
    .rsp_fault       (rsp_fault),
    .rsp_side_effect (rsp_side_effect),
    .event_i         (event_i),
    .irq_o           (irq_o)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: a response is consumed at the next rising edge when
  // rsp_valid && rsp_ready, both stable from the falling edge onward.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && rsp_valid && rsp_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected got rdata=%h fault=%b se=%b", rsp_rdata, rsp_fault, rsp_side_effect);
      end else begin
        e = sb.pop_front();
        if (rsp_rdata !== e.rdata || rsp_fault !== e.fault || rsp_side_effect !== e.se) begin
          bad++;
          $display("FAIL rsp_%s got rdata=%h fault=%b se=%b want rdata=%h fault=%b se=%b",
                   e.name, rsp_rdata, rsp_fault, rsp_side_effect, e.rdata, e.fault, e.se);
        end
      end
    end
  end

  // Drive one request starting at a falling edge; returns at the falling
  // edge after acceptance with req_valid dropped.
  task automatic send(input string name, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb, input logic [1:0] priv,
                      input logic [31:0] exp_rdata, input logic exp_fault, input logic exp_se);
    exp_t e;
    last_stalls = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = strb;
    req_priv  = priv;
    #1;
    while (!req_ready && last_stalls < 50) begin
      @(negedge clk);
      #1;
      last_stalls++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL %s_accept_timeout got req_ready=%b want 1", name, req_ready);
    end else begin
      e.name  = name;
      e.rdata = exp_rdata;
      e.fault = exp_fault;
      e.se    = exp_se;
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while (sb.size() != 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    #3;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout got pending=%0d want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    req_wstrb = 4'd0; req_priv = 2'd1; rsp_ready = 1'b1; event_i = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    total += 6;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    if (rsp_rdata !== 32'd0) begin bad++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
    if (rsp_fault !== 1'b0) begin bad++; $display("FAIL reset_rsp_fault got %b want 0", rsp_fault); end
    if (rsp_side_effect !== 1'b0) begin bad++; $display("FAIL reset_rsp_se got %b want 0", rsp_side_effect); end
    if (irq_o !== 1'b0) begin bad++; $display("FAIL reset_irq got %b want 0", irq_o); end
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_id_read();
    send("id_read", 1'b0, 32'h100, 32'd0, 4'h0, 2'd1, 32'hCA2B_0001, 1'b0, 1'b0);
    total++;
    if (rsp_valid !== 1'b1) begin bad++; $display("FAIL id_latency got rsp_valid=%b want 1", rsp_valid); end
    drain();
  endtask

  task automatic test_scratch();
    send("scr_wr_strb", 1'b1, 32'h110, 32'hDEAD_BEEF, 4'b0101, 2'd1, 32'd0, 1'b0, 1'b0);
    send("scr_rd_strb", 1'b0, 32'h110, 32'd0, 4'h0, 2'd1, 32'h00AD_00EF, 1'b0, 1'b0);
    send("scr_wr_nostrb", 1'b1, 32'h110, 32'hFFFF_FFFF, 4'b0000, 2'd1, 32'd0, 1'b0, 1'b0);
    send("scr_rd_nostrb", 1'b0, 32'h110, 32'd0, 4'h0, 2'd1, 32'h00AD_00EF, 1'b0, 1'b0);
    send("scr_wr_last", 1'b1, 32'h11C, 32'h1234_5678, 4'hF, 2'd3, 32'd0, 1'b0, 1'b0);
    send("scr_rd_last", 1'b0, 32'h11C, 32'd0, 4'h0, 2'd1, 32'h1234_5678, 1'b0, 1'b0);
    send("scr_wr_other", 1'b1, 32'h114, 32'hA5A5_5A5A, 4'hF, 2'd1, 32'd0, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_event();
    event_i = 32'h5;
    @(negedge clk);
    event_i = 32'h0;
    #1;
    total++;
    if (irq_o !== 1'b0) begin bad++; $display("FAIL irq_early got %b want 0", irq_o); end
    @(negedge clk);
    #1;
    total++;
    if (irq_o !== 1'b1) begin bad++; $display("FAIL irq_set got %b want 1", irq_o); end
    @(negedge clk);
    send("evt_clr0", 1'b1, 32'h104, 32'h1, 4'hF, 2'd1, 32'd0, 1'b0, 1'b1);
    send("evt_rd4", 1'b0, 32'h104, 32'd0, 4'h0, 2'd1, 32'h4, 1'b0, 1'b0);
    event_i = 32'h1;
    send("evt_clr_vs_set", 1'b1, 32'h104, 32'h1, 4'hF, 2'd1, 32'd0, 1'b0, 1'b1);
    event_i = 32'h0;
    send("evt_rd5", 1'b0, 32'h104, 32'd0, 4'h0, 2'd1, 32'h5, 1'b0, 1'b0);
    send("evt_clr_nostrb", 1'b1, 32'h104, 32'h5, 4'h0, 2'd1, 32'd0, 1'b0, 1'b0);
    send("evt_rd5b", 1'b0, 32'h104, 32'd0, 4'h0, 2'd1, 32'h5, 1'b0, 1'b0);
    #1;
    total++;
    if (irq_o !== 1'b1) begin bad++; $display("FAIL irq_held got %b want 1", irq_o); end
    @(negedge clk);
    send("evt_clr_all", 1'b1, 32'h104, 32'hFFFF_FFFF, 4'hF, 2'd1, 32'd0, 1'b0, 1'b1);
    send("evt_rd0", 1'b0, 32'h104, 32'd0, 4'h0, 2'd1, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    total++;
    if (irq_o !== 1'b0) begin bad++; $display("FAIL irq_clear got %b want 0", irq_o); end
    drain();
  endtask

  task automatic test_cycle();
    @(negedge clk);
`ifdef CARBON_CSR_BANK_CYCLE_CNT_EN
    force dut.cycle_r = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.cycle_r;
    send("cyc_lo", 1'b0, 32'h108, 32'd0, 4'h0, 2'd1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    send("cyc_hi_shadow", 1'b0, 32'h10C, 32'd0, 4'h0, 2'd1, 32'h0000_0000, 1'b0, 1'b0);
`else
    send("cyc_lo_absent", 1'b0, 32'h108, 32'd0, 4'h0, 2'd1, 32'd0, 1'b1, 1'b0);
    send("cyc_hi_absent", 1'b0, 32'h10C, 32'd0, 4'h0, 2'd1, 32'd0, 1'b1, 1'b0);
`endif
    send("cyc_wr_ro", 1'b1, 32'h108, 32'h1, 4'hF, 2'd1, 32'd0, 1'b1, 1'b0);
    drain();
  endtask

  task automatic test_faults();
    send("flt_wr_id", 1'b1, 32'h100, 32'h1111_2222, 4'hF, 2'd1, 32'd0, 1'b1, 1'b0);
    send("id_after_wr", 1'b0, 32'h100, 32'd0, 4'h0, 2'd1, 32'hCA2B_0001, 1'b0, 1'b0);
    send("flt_misalign", 1'b0, 32'h102, 32'd0, 4'h0, 2'd1, 32'd0, 1'b1, 1'b0);
    send("flt_priv", 1'b0, 32'h100, 32'd0, 4'h0, 2'd0, 32'd0, 1'b1, 1'b0);
    send("flt_below", 1'b0, 32'h0FC, 32'd0, 4'h0, 2'd1, 32'd0, 1'b1, 1'b0);
    send("flt_unmapped", 1'b0, 32'h120, 32'd0, 4'h0, 2'd1, 32'd0, 1'b1, 1'b0);
    send("flt_wr_misalign", 1'b1, 32'h111, 32'hFFFF_FFFF, 4'hF, 2'd1, 32'd0, 1'b1, 1'b0);
    send("flt_wr_priv", 1'b1, 32'h110, 32'hFFFF_FFFF, 4'hF, 2'd0, 32'd0, 1'b1, 1'b0);
    send("scr_after_flt", 1'b0, 32'h110, 32'd0, 4'h0, 2'd1, 32'h00AD_00EF, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    rsp_ready = 1'b0;
    send("bp_first", 1'b0, 32'h110, 32'd0, 4'h0, 2'd1, 32'h00AD_00EF, 1'b0, 1'b0);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h100; req_priv = 2'd1;
    for (int c = 0; c < 5; c++) begin
      #1;
      total += 2;
      if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_c%0d got %b want 0", c, req_ready); end
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h00AD_00EF || rsp_fault !== 1'b0 || rsp_side_effect !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold_c%0d got v=%b rdata=%h f=%b se=%b want v=1 rdata=00ad00ef f=0 se=0",
                 c, rsp_valid, rsp_rdata, rsp_fault, rsp_side_effect);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    send("b2b_id", 1'b0, 32'h100, 32'd0, 4'h0, 2'd1, 32'hCA2B_0001, 1'b0, 1'b0);
    total++;
    if (last_stalls != 0) begin bad++; $display("FAIL b2b_release_stall got %0d want 0", last_stalls); end
    send("b2b_evt", 1'b0, 32'h104, 32'd0, 4'h0, 2'd1, 32'h0, 1'b0, 1'b0);
    total++;
    if (last_stalls != 0) begin bad++; $display("FAIL b2b_stall2 got %0d want 0", last_stalls); end
    send("b2b_scr0", 1'b0, 32'h110, 32'd0, 4'h0, 2'd1, 32'h00AD_00EF, 1'b0, 1'b0);
    send("b2b_scr3", 1'b0, 32'h11C, 32'd0, 4'h0, 2'd1, 32'h1234_5678, 1'b0, 1'b0);
    total++;
    if (last_stalls != 0) begin bad++; $display("FAIL b2b_stall4 got %0d want 0", last_stalls); end
    // Fourth response is drained on the fifth edge; nothing valid after it.
    @(negedge clk);
    #1;
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_done got rsp_valid=%b want 0", rsp_valid); end
    drain();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rsp_ready = 1'b0;
    send("mid_dropped", 1'b0, 32'h100, 32'd0, 4'h0, 2'd1, 32'hCA2B_0001, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    total += 2;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_rsp_drop got %b want 0", rsp_valid); end
    if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got %b want 1", req_ready); end
    void'(sb.pop_back());
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h114;
    req_wdata = 32'hFFFF_FFFF; req_wstrb = 4'hF; req_priv = 2'd1;
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    send("mid_no_write", 1'b0, 32'h114, 32'd0, 4'h0, 2'd1, 32'd0, 1'b0, 1'b0);
    send("mid_scr_reset", 1'b0, 32'h110, 32'd0, 4'h0, 2'd1, 32'd0, 1'b0, 1'b0);
    drain();
  endtask

  initial begin
    test_reset();
    test_id_read();
    test_scratch();
    test_event();
    test_cycle();
    test_faults();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
